// File: rtl/interrupt_request_latch_if.sv
// Sequencer-side service handshake of the interrupt request latch.
// The sequencer drives master; the latch drives slave.
interface interrupt_request_latch_if;
    logic       Fetch_Sync;
    logic       Ack;
    logic       Int_Take;
    logic [1:0] Vector_Sel;

    modport master (
        output Fetch_Sync,
        output Ack,
        input  Int_Take,
        input  Vector_Sel
    );

    modport slave (
        input  Fetch_Sync,
        input  Ack,
        output Int_Take,
        output Vector_Sel
    );
endinterface

// File: rtl/interrupt_request_latch.sv
// Synchronises and qualifies RES/NMI/IRQ pins into pending bits and runs the vector service handshake.
// Optional macro IRQ_GLITCH_FILTER_EN: IRQ must be low on two consecutive enabled samples.
module interrupt_request_latch #(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned ResMinCycles = 2
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Phi2_En,
    input  logic                         RES_n,
    input  logic                         NMI_n,
    input  logic                         IRQ_n,
    input  logic                         I_Flag,
    interrupt_request_latch_if.slave     seq,
    output logic                         Res_Pending,
    output logic                         Nmi_Pending,
    output logic                         Irq_Pending
);
    localparam logic [1:0] VEC_NONE = 2'b00;
    localparam logic [1:0] VEC_IRQ  = 2'b01;
    localparam logic [1:0] VEC_NMI  = 2'b10;
    localparam logic [1:0] VEC_RES  = 2'b11;
    localparam logic [3:0] CNT_MAX  = 4'(ResMinCycles);

    typedef enum logic {IDLE, SERVICE} state_t;

    state_t                state;
    logic [SyncStages-1:0] res_sync;
    logic [SyncStages-1:0] nmi_sync;
    logic [SyncStages-1:0] irq_sync;
    logic                  res_s;
    logic                  nmi_s;
    logic                  irq_s;
    logic                  nmi_prev;
    logic [3:0]            res_cnt;
    logic [3:0]            res_cnt_next;
    logic                  res_hit;
    logic                  nmi_edge;
    logic                  irq_level;
    logic                  int_take;
    logic [1:0]            vector_sel;
    logic                  ack_clear;

    assign seq.Int_Take   = int_take;
    assign seq.Vector_Sel = vector_sel;

    assign res_s = res_sync[SyncStages-1];
    assign nmi_s = nmi_sync[SyncStages-1];
    assign irq_s = irq_sync[SyncStages-1];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            res_sync <= '1;
            nmi_sync <= '1;
            irq_sync <= '1;
        end else begin
            res_sync <= {res_sync[SyncStages-2:0], RES_n};
            nmi_sync <= {nmi_sync[SyncStages-2:0], NMI_n};
            irq_sync <= {irq_sync[SyncStages-2:0], IRQ_n};
        end
    end

`ifdef IRQ_GLITCH_FILTER_EN
    logic irq_filt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            irq_filt <= 1'b1;
        end else if (Phi2_En) begin
            irq_filt <= irq_s;
        end
    end

    assign irq_level = ~irq_s & ~irq_filt;
`else
    assign irq_level = ~irq_s;
`endif

    always_comb begin
        res_cnt_next = '0;
        if (!res_s) begin
            res_cnt_next = (res_cnt == CNT_MAX) ? res_cnt : res_cnt + 4'd1;
        end
        res_hit  = !res_s && (res_cnt_next == CNT_MAX);
        nmi_edge = nmi_prev & ~nmi_s;
        // Ack only counts while servicing; in IDLE it is ignored entirely.
        ack_clear = (state == SERVICE) && seq.Ack;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            res_cnt     <= '0;
            nmi_prev    <= 1'b1;
            Res_Pending <= 1'b1;
            Nmi_Pending <= 1'b0;
            Irq_Pending <= 1'b0;
            int_take    <= 1'b0;
            vector_sel  <= VEC_NONE;
        end else if (Phi2_En) begin
            res_cnt     <= res_cnt_next;
            nmi_prev    <= nmi_s;
            Irq_Pending <= irq_level & ~I_Flag;

            // A fresh qualification or edge beats a clear from the same Ack.
            if (res_hit) begin
                Res_Pending <= 1'b1;
            end else if (ack_clear && vector_sel == VEC_RES && res_s) begin
                Res_Pending <= 1'b0;
            end

            if (nmi_edge) begin
                Nmi_Pending <= 1'b1;
            end else if (ack_clear && vector_sel == VEC_NMI) begin
                Nmi_Pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (seq.Fetch_Sync && (Res_Pending || Nmi_Pending || Irq_Pending)) begin
                        state    <= SERVICE;
                        int_take <= 1'b1;
                        if (Res_Pending) begin
                            vector_sel <= VEC_RES;
                        end else if (Nmi_Pending) begin
                            vector_sel <= VEC_NMI;
                        end else begin
                            vector_sel <= VEC_IRQ;
                        end
                    end
                end
                SERVICE: begin
                    if (seq.Ack) begin
                        state      <= IDLE;
                        int_take   <= 1'b0;
                        vector_sel <= VEC_NONE;
                    end else if (Res_Pending && vector_sel != VEC_RES) begin
                        vector_sel <= VEC_RES;
                    end
                end
                default: begin
                    state      <= IDLE;
                    int_take   <= 1'b0;
                    vector_sel <= VEC_NONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_request_latch.sv
// Directed scoreboard bench for interrupt_request_latch (SyncStages=2, ResMinCycles=2).
// Observed word is {Res_Pending, Nmi_Pending, Irq_Pending, Int_Take, Vector_Sel}.
module tb_interrupt_request_latch;
    logic Clock = 1'b0;
    logic Reset;
    logic Phi2_En;
    logic RES_n;
    logic NMI_n;
    logic IRQ_n;
    logic I_Flag;
    logic Res_Pending;
    logic Nmi_Pending;
    logic Irq_Pending;

    interrupt_request_latch_if bus ();

    interrupt_request_latch #(
        .SyncStages  (2),
        .ResMinCycles(2)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Phi2_En    (Phi2_En),
        .RES_n      (RES_n),
        .NMI_n      (NMI_n),
        .IRQ_n      (IRQ_n),
        .I_Flag     (I_Flag),
        .seq        (bus.slave),
        .Res_Pending(Res_Pending),
        .Nmi_Pending(Nmi_Pending),
        .Irq_Pending(Irq_Pending)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string      tag;
        logic [5:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [5:0]  obs;

    assign obs = {Res_Pending, Nmi_Pending, Irq_Pending, bus.Int_Take, bus.Vector_Sel};

    task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (R N I T VV)", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic sb_push(input string tag, input logic [5:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 6'b111111, 6'b000000);
        end else begin
            e = sb.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    // Push the expectation, let n edges pass, then compare.
    task automatic expect_after(input int unsigned n, input string tag, input logic [5:0] v);
        sb_push(tag, v);
        step(n);
        sb_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Phi2_En = 1'b1;
        RES_n = 1'b1;
        NMI_n = 1'b1;
        IRQ_n = 1'b1;
        I_Flag = 1'b1;
        bus.Fetch_Sync = 1'b0;
        bus.Ack = 1'b0;

        expect_after(2, "reset_state", 6'b100000);
        Reset = 1'b0;

        // Power-up reset service
        bus.Fetch_Sync = 1'b1;
        expect_after(1, "pwr_take_res", 6'b100111);
        bus.Fetch_Sync = 1'b0;
        bus.Ack = 1'b1;
        expect_after(1, "pwr_ack_clear", 6'b000000);
        expect_after(1, "ack_in_idle", 6'b000000);
        bus.Ack = 1'b0;

        // NMI edge latency and no retrigger while held
        NMI_n = 1'b0;
        expect_after(2, "nmi_not_yet", 6'b000000);
        expect_after(1, "nmi_3rd_edge", 6'b010000);
        bus.Fetch_Sync = 1'b1;
        expect_after(1, "nmi_take", 6'b010110);
        bus.Fetch_Sync = 1'b0;
        bus.Ack = 1'b1;
        expect_after(1, "nmi_ack", 6'b000000);
        bus.Ack = 1'b0;
        expect_after(5, "nmi_held_no_retrig", 6'b000000);
        NMI_n = 1'b1;
        expect_after(3, "nmi_release", 6'b000000);

        // NMI edge coinciding with the NMI Ack
        NMI_n = 1'b0;
        expect_after(3, "col_nmi_set", 6'b010000);
        bus.Fetch_Sync = 1'b1;
        expect_after(1, "col_take", 6'b010110);
        bus.Fetch_Sync = 1'b0;
        NMI_n = 1'b1;
        expect_after(3, "col_release", 6'b010110);
        NMI_n = 1'b0;
        expect_after(2, "col_pre_edge", 6'b010110);
        bus.Ack = 1'b1;
        expect_after(1, "col_set_wins", 6'b010000);
        bus.Ack = 1'b0;
        bus.Fetch_Sync = 1'b1;
        expect_after(1, "col_retake", 6'b010110);
        bus.Fetch_Sync = 1'b0;
        bus.Ack = 1'b1;
        expect_after(1, "col_ack2", 6'b000000);
        bus.Ack = 1'b0;
        NMI_n = 1'b1;
        expect_after(3, "col_idle", 6'b000000);

        // IRQ masking by I flag
        IRQ_n = 1'b0;
        expect_after(4, "irq_masked", 6'b000000);
        I_Flag = 1'b0;
        expect_after(1, "irq_unmasked", 6'b001000);
        bus.Fetch_Sync = 1'b1;
        expect_after(1, "irq_take", 6'b001101);
        bus.Fetch_Sync = 1'b0;

        // Qualified RES overrides IRQ service; Ack with RES still low keeps it pending
        RES_n = 1'b0;
        expect_after(3, "ovr_cnt1", 6'b001101);
        expect_after(1, "ovr_res_qual", 6'b101101);
        expect_after(1, "ovr_vec_res", 6'b101111);
        RES_n = 1'b1;
        bus.Ack = 1'b1;
        expect_after(1, "ovr_ack_res_low", 6'b101000);
        bus.Ack = 1'b0;
        expect_after(2, "ovr_idle_hold", 6'b101000);
        bus.Fetch_Sync = 1'b1;
        expect_after(1, "ovr_retake_res", 6'b101111);
        bus.Fetch_Sync = 1'b0;
        bus.Ack = 1'b1;
        expect_after(1, "ovr_ack_res_high", 6'b001000);
        bus.Ack = 1'b0;

        // Priority RES > NMI > IRQ
        RES_n = 1'b0;
        NMI_n = 1'b0;
        expect_after(4, "pri_all_pending", 6'b111000);
        RES_n = 1'b1;
        bus.Fetch_Sync = 1'b1;
        expect_after(1, "pri_take_res", 6'b111111);
        bus.Fetch_Sync = 1'b0;
        expect_after(2, "pri_hold_res", 6'b111111);
        bus.Ack = 1'b1;
        expect_after(1, "pri_ack_res", 6'b011000);
        bus.Ack = 1'b0;
        bus.Fetch_Sync = 1'b1;
        expect_after(1, "pri_take_nmi", 6'b011110);
        bus.Fetch_Sync = 1'b0;
        bus.Ack = 1'b1;
        expect_after(1, "pri_ack_nmi", 6'b001000);
        bus.Ack = 1'b0;
        bus.Fetch_Sync = 1'b1;
        expect_after(1, "pri_take_irq", 6'b001101);
        bus.Fetch_Sync = 1'b0;
        bus.Ack = 1'b1;
        expect_after(1, "pri_ack_irq", 6'b001000);

        // Fetch_Sync and Ack together in IDLE: Ack ignored
        bus.Fetch_Sync = 1'b1;
        expect_after(1, "fetch_ack_idle", 6'b001101);
        bus.Fetch_Sync = 1'b0;
        NMI_n = 1'b1;

        // Phi2_En low freezes everything
        Phi2_En = 1'b0;
        IRQ_n = 1'b1;
        expect_after(3, "phi2_hold", 6'b001101);
        Phi2_En = 1'b1;
        expect_after(1, "phi2_resume", 6'b000000);
        bus.Ack = 1'b0;

        // Asynchronous reset mid-service
        IRQ_n = 1'b0;
        expect_after(4, "mid_irq", 6'b001000);
        bus.Fetch_Sync = 1'b1;
        expect_after(1, "mid_take", 6'b001101);
        bus.Fetch_Sync = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        sb_push("mid_async_reset", 6'b100000);
        sb_check();
        IRQ_n = 1'b1;
        step(2);
        Reset = 1'b0;
        step(3);

        // Single-sample IRQ pulse, then two-sample pulse
        IRQ_n = 1'b0;
        step(1);
        IRQ_n = 1'b1;
`ifdef IRQ_GLITCH_FILTER_EN
        expect_after(5, "glitch_1sample", 6'b100000);
        IRQ_n = 1'b0;
        step(2);
        IRQ_n = 1'b1;
        expect_after(2, "glitch_2sample", 6'b101000);
        expect_after(1, "glitch_2sample_end", 6'b100000);
`else
        expect_after(2, "pulse_1sample", 6'b101000);
        expect_after(1, "pulse_1sample_end", 6'b100000);
`endif

        if (sb.size() != 0) begin
            check_eq("scoreboard_leftover", 6'(sb.size()), 6'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/interrupt_request_latch.md
Name: interrupt_request_latch

Overview:
- Upstream stage of the CPU's 3-input interrupt-pending OR gate.
- Synchronises the external active-low RES_n, NMI_n and IRQ_n pins and qualifies them: RES by minimum low time, NMI by falling edge, IRQ by level masked with the I flag.
- Drives the three pending bits that the OR gate combines.
- Runs the service handshake with the sequencer: capture at the opcode-fetch boundary, select the vector, clear on acknowledge.

Parameters:
- SyncStages, 2, synchroniser depth for each pin (legal 2..4).
- ResMinCycles, 2, consecutive enabled samples of RES low needed to qualify reset (legal 1..15).

Ports:
- Clock  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- Phi2_En  input  1  CPU phase enable; all qualification and state updates happen only when 1.
- RES_n  input  1  external reset pin, active low, asynchronous.
- NMI_n  input  1  external NMI pin, active low, asynchronous.
- IRQ_n  input  1  external IRQ pin, active low, asynchronous.
- I_Flag  input  1  processor status I bit; 1 masks IRQ.
- Fetch_Sync  input  1  opcode-fetch boundary (SYNC) from the sequencer.
- Ack  input  1  vector fetch complete; one-cycle pulse.
- Res_Pending  output  1  qualified reset request (OR-gate input 1).
- Nmi_Pending  output  1  latched NMI edge (OR-gate input 2).
- Irq_Pending  output  1  unmasked IRQ level (OR-gate input 3).
- Int_Take  output  1  high while an interrupt is in service.
- Vector_Sel  output  2  11 = RES ($FFFC), 10 = NMI ($FFFA), 01 = IRQ/BRK ($FFFE), 00 = none.

Behaviour:
- Reset values:
  - Synchroniser flops = 1 (pins inactive).
  - Res_Pending = 1, so a power-up reset sequence follows.
  - Nmi_Pending = 0, Irq_Pending = 0, Int_Take = 0, Vector_Sel = 00.
  - State = IDLE; RES counter = 0.
- Synchronisers:
  - SyncStages flops per pin, clocked every Clock edge, not gated by Phi2_En.
- Qualification (Phi2_En = 1 cycles only):
  - RES: the counter increments, saturating at ResMinCycles, while synced RES is low, and resets to 0 when synced RES is high. Res_Pending sets when the count reaches ResMinCycles.
  - NMI: previous enabled sample 1 and current sample 0 sets Nmi_Pending. A held-low NMI does not retrigger. A new edge is needed after a release.
  - IRQ: Irq_Pending <= (synced IRQ low) & ~I_Flag. This is a registered level with no latching.
- Latency:
  - Pin to synced value: SyncStages clocks.
  - Synced value to pending bit: next enabled cycle.
- State machine:
  - IDLE -> SERVICE on an enabled cycle with Fetch_Sync = 1 and any pending bit set.
  - On that transition, Vector_Sel is captured by priority RES > NMI > IRQ.
  - SERVICE: Int_Take = 1 and Vector_Sel is frozen.
  - SERVICE -> IDLE on Ack = 1. This transition also sets Vector_Sel = 00 and Int_Take = 0.
- Ack clearing (applied in the same cycle as the return to IDLE):
  - NMI served: clear Nmi_Pending.
  - RES served: clear Res_Pending only if synced RES is high. Otherwise stay pending and re-enter SERVICE at the next Fetch_Sync.
  - IRQ served: no clear; the level path re-evaluates.
- Simultaneous events:
  - NMI edge in the same enabled cycle as an Ack that clears NMI: the set wins and Nmi_Pending stays 1.
  - Qualified RES during SERVICE with Vector_Sel = NMI or IRQ: Vector_Sel becomes 11 the next cycle and remains in SERVICE.
  - NMI arriving during IRQ service is not pre-empting. It is latched and taken at the next Fetch_Sync.
  - Fetch_Sync and Ack both high in IDLE: Ack is ignored.
  - Ack while in IDLE: ignored.
  - Phi2_En = 0: state, pending bits and counter hold.
- Reset asserted mid-service: immediate asynchronous return to the reset values. The NMI edge history is lost.

Optional Feature:
- Macro: IRQ_GLITCH_FILTER_EN.
- Defined: Irq_Pending requires synced IRQ low on 2 consecutive enabled samples. A single-sample low pulse never sets Irq_Pending. The filter flop resets to 1.
- Undefined: single-sample IRQ level as described above. No extra flop.

Test Plan:
- Power-up: release Reset with RES_n = 1, pulse Fetch_Sync -> Res_Pending = 1 out of reset. SERVICE entered with Vector_Sel = 11, Int_Take = 1. Ack -> Res_Pending = 0, Vector_Sel = 00.
- NMI edge: NMI_n 1 -> 0 held 20 cycles, SyncStages = 2 -> Nmi_Pending = 1 at the 3rd Clock edge after the drop (with Phi2_En = 1). After Fetch_Sync and then Ack, Nmi_Pending = 0 and does not re-set while NMI_n stays low.
- IRQ masking: IRQ_n = 0, I_Flag = 1 -> Irq_Pending stays 0. Set I_Flag = 0 -> Irq_Pending = 1 on the next enabled cycle. Fetch_Sync -> Vector_Sel = 01.
- Priority: RES, NMI and IRQ all asserted before Fetch_Sync -> Vector_Sel = 11. After Ack with RES_n high -> NMI (10) taken at the next Fetch_Sync, then IRQ (01).
- Collision and override: NMI edge in the same cycle as an NMI Ack -> Nmi_Pending stays 1. RES_n low for ResMinCycles enabled samples during IRQ service -> Vector_Sel switches 01 -> 11.
- Mid-service Reset and filter: assert Reset during SERVICE -> all outputs return to reset values immediately. With IRQ_GLITCH_FILTER_EN, a 1-enabled-sample IRQ_n pulse -> Irq_Pending stays 0; a 2-sample pulse -> Irq_Pending = 1.
